// File: rtl/vl_pkg.sv
// rtl/vl_pkg.sv - shared types, widths and code checks for the vl strip sequencer
package vl_pkg;

    localparam int AVL_W = 9;
    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        SEW_4  = 3'b000,
        SEW_8  = 3'b001,
        SEW_16 = 3'b010,
        SEW_32 = 3'b011,
        SEW_64 = 3'b100
    } sew_e;

    typedef enum logic [2:0] {
        LMUL_1  = 3'b000,
        LMUL_2  = 3'b001,
        LMUL_4  = 3'b010,
        LMUL_8  = 3'b011,
        LMUL_16 = 3'b100
    } lmul_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    function automatic logic codes_legal(input logic [2:0] sew, input logic [2:0] lmul);
        return (sew <= SEW_64) && (lmul <= LMUL_16);
    endfunction

endpackage

// File: rtl/vlmax_calc.sv
// rtl/vlmax_calc.sv - combinational vlmax and legality from SEW/LMUL codes
module vlmax_calc
    import vl_pkg::*;
#(
    parameter int VLEN = 64
) (
    input  logic [2:0]       sew,
    input  logic [2:0]       lmul,
    output logic [AVL_W-1:0] vlmax,
    output logic             legal
);

    logic [4:0]       sew_shift;
    logic [AVL_W-1:0] per_reg;

    // Elements per register, scaled by the register group size; a zero result
    // (small VLEN with wide SEW) is treated as illegal so a job can never stall.
    always_comb begin
        sew_shift = {2'b00, sew} + 5'd2;
        per_reg   = AVL_W'(VLEN >> sew_shift);
        vlmax     = per_reg << lmul;
        legal     = codes_legal(sew, lmul) && (vlmax != '0);
    end

endmodule

// File: rtl/vl_strip_sequencer.sv
// rtl/vl_strip_sequencer.sv - strip-mines one AVL into a back-pressurable stream of vl chunks
module vl_strip_sequencer
    import vl_pkg::*;
#(
    parameter int VLEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_sew,
    input  logic [2:0]       cfg_lmul,
    input  logic [AVL_W-1:0] cfg_avl,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic [AVL_W-1:0] chunk_vl,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             chunk_last,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_e           state_q, state_n;
    logic [AVL_W-1:0] vlmax_q, vlmax_n;
    logic [AVL_W-1:0] remaining_q, remaining_n;
    logic [AVL_W-1:0] vl_q, vl_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             last_q, last_n;
    logic             done_q, done_n;
    logic             err_q, err_n;

    logic [AVL_W-1:0] cfg_vlmax;
    logic             cfg_legal;
    logic [AVL_W-1:0] rem_after;

    vlmax_calc #(
        .VLEN (VLEN)
    ) u_vlmax_calc (
        .sew   (cfg_sew),
        .lmul  (cfg_lmul),
        .vlmax (cfg_vlmax),
        .legal (cfg_legal)
    );

    // Cannot underflow: the current chunk never exceeds what remains.
    assign rem_after = remaining_q - vl_q;

    // State and chunk registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vlmax_q     <= '0;
            remaining_q <= '0;
            vl_q        <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            vlmax_q     <= vlmax_n;
            remaining_q <= remaining_n;
            vl_q        <= vl_n;
            idx_q       <= idx_n;
            last_q      <= last_n;
            done_q      <= done_n;
            err_q       <= err_n;
        end
    end

    // Next state and next chunk; abort beats a simultaneous handshake.
    always_comb begin
        state_n     = state_q;
        vlmax_n     = vlmax_q;
        remaining_n = remaining_q;
        vl_n        = vl_q;
        idx_n       = idx_q;
        last_n      = last_q;
        done_n      = 1'b0;
        err_n       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (!cfg_legal || (cfg_avl == '0)) begin
                        err_n = 1'b1;
                    end else begin
                        vlmax_n     = cfg_vlmax;
                        remaining_n = cfg_avl;
                        idx_n       = '0;
                        vl_n        = (cfg_avl < cfg_vlmax) ? cfg_avl : cfg_vlmax;
                        last_n      = (cfg_avl <= cfg_vlmax);
                        state_n     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (chunk_ready) begin
                    if (last_q) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        remaining_n = rem_after;
                        idx_n       = idx_q + IDX_W'(1);
                        vl_n        = (rem_after < vlmax_q) ? rem_after : vlmax_q;
                        last_n      = (rem_after <= vlmax_q);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign chunk_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_ISSUE);
    assign chunk_vl    = vl_q;
    assign chunk_idx   = idx_q;
    assign chunk_last  = last_q;
    assign done        = done_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_vl_strip_sequencer.sv
// tb/tb_vl_strip_sequencer.sv - scoreboard bench for vl_strip_sequencer
module tb_vl_strip_sequencer;

    typedef struct packed {
        logic [8:0] vl;
        logic [7:0] idx;
        logic       last;
    } chunk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_sew;
    logic [2:0] cfg_lmul;
    logic [8:0] cfg_avl;
    logic       chunk_valid;
    logic       chunk_ready;
    logic [8:0] chunk_vl;
    logic [7:0] chunk_idx;
    logic       chunk_last;
    logic       abort;
    logic       busy;
    logic       done;
    logic       cfg_err;

    chunk_t sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     sew_tab[5]  = '{4, 8, 16, 32, 64};
    int     lmul_tab[5] = '{1, 2, 4, 8, 16};

    vl_strip_sequencer #(
        .VLEN (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sew     (cfg_sew),
        .cfg_lmul    (cfg_lmul),
        .cfg_avl     (cfg_avl),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_vl    (chunk_vl),
        .chunk_idx   (chunk_idx),
        .chunk_last  (chunk_last),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_cfg_ready"}, cfg_ready, 1);
        check_val({tag, "_chunk_valid"}, chunk_valid, 0);
        check_val({tag, "_chunk_vl"}, chunk_vl, 0);
        check_val({tag, "_chunk_idx"}, chunk_idx, 0);
        check_val({tag, "_chunk_last"}, chunk_last, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Offer one configuration (called at a negedge); legal jobs push their chunks.
    task automatic send_cfg(input logic [2:0] sew, input logic [2:0] lmul,
                            input logic [8:0] avl, input bit with_abort);
        int vmax, rem, idx, v;
        bit ok;
        chunk_t c;
        check_val("cfg_ready_pre", cfg_ready, 1);
        ok = (sew < 3'd5) && (lmul < 3'd5) && (avl != 9'd0);
        cfg_valid = 1'b1;
        cfg_sew   = sew;
        cfg_lmul  = lmul;
        cfg_avl   = avl;
        abort     = with_abort;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        if (ok) begin
            vmax = 64 * lmul_tab[lmul] / sew_tab[sew];
            rem  = int'(avl);
            idx  = 0;
            while (rem > 0) begin
                v      = (rem < vmax) ? rem : vmax;
                c.vl   = 9'(v);
                c.idx  = 8'(idx);
                c.last = (rem == v);
                sb.push_back(c);
                rem -= v;
                idx++;
            end
        end else begin
            @(negedge clk);
            check_val("rej_cfg_err", cfg_err, 1);
            check_val("rej_chunk_valid", chunk_valid, 0);
            check_val("rej_cfg_ready", cfg_ready, 1);
            @(negedge clk);
            check_val("rej_cfg_err_clr", cfg_err, 0);
            check_val("rej_chunk_valid2", chunk_valid, 0);
        end
    endtask

    // Consume queued chunks; ready is held low for the first 'stall' cycles.
    task automatic drain(input int stall);
        int     cyc;
        int     st;
        bit     fin;
        chunk_t e;
        fin = 1'b0;
        cyc = 0;
        st  = stall;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check_val("chunk_valid", chunk_valid, 1);
            check_val("busy", busy, 1);
            check_val("done_mid", done, 0);
            if (sb.size() == 0) begin
                check_val("sb_empty", 1, 0);
                break;
            end
            e = sb[0];
            check_val("chunk_vl", chunk_vl, e.vl);
            check_val("chunk_idx", chunk_idx, e.idx);
            check_val("chunk_last", chunk_last, e.last);
            if (st > 0) begin
                chunk_ready = 1'b0;
                st--;
            end else begin
                chunk_ready = 1'b1;
                void'(sb.pop_front());
                fin = e.last;
            end
        end
        if (!fin) check_val("drain_timeout", 0, 1);
        @(negedge clk);
        chunk_ready = 1'b0;
        check_val("done_pulse", done, 1);
        check_val("cfg_ready_after", cfg_ready, 1);
        check_val("chunk_valid_after", chunk_valid, 0);
        check_val("busy_after", busy, 0);
        @(negedge clk);
        check_val("done_clear", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_sew     = 3'd0;
        cfg_lmul    = 3'd0;
        cfg_avl     = 9'd0;
        chunk_ready = 1'b0;
        abort       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        send_cfg(3'd1, 3'd1, 9'd40, 1'b0);
        drain(0);

        send_cfg(3'd4, 3'd0, 9'd3, 1'b1);
        drain(0);

        send_cfg(3'd0, 3'd4, 9'd256, 1'b0);
        drain(0);

        send_cfg(3'd1, 3'd1, 9'd32, 1'b0);
        drain(3);

        send_cfg(3'd5, 3'd0, 9'd10, 1'b0);
        send_cfg(3'd1, 3'd6, 9'd10, 1'b0);
        send_cfg(3'd1, 3'd1, 9'd0, 1'b0);

        send_cfg(3'd1, 3'd1, 9'd40, 1'b0);
        @(negedge clk);
        check_val("abort_idx0", chunk_idx, 0);
        chunk_ready = 1'b1;
        @(negedge clk);
        check_val("abort_idx1", chunk_idx, 1);
        check_val("abort_vl1", chunk_vl, 16);
        abort = 1'b1;
        @(negedge clk);
        abort       = 1'b0;
        chunk_ready = 1'b0;
        check_val("abort_valid", chunk_valid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_cfg_ready", cfg_ready, 1);
        check_val("abort_done", done, 0);
        sb.delete();
        send_cfg(3'd4, 3'd0, 9'd3, 1'b0);
        drain(0);

        send_cfg(3'd1, 3'd1, 9'd40, 1'b0);
        @(negedge clk);
        check_val("rst_mid_valid", chunk_valid, 1);
        chunk_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async_valid", chunk_valid, 0);
        check_val("rst_async_busy", busy, 0);
        check_val("rst_async_vl", chunk_vl, 0);
        @(negedge clk);
        chunk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_release");
        sb.delete();
        send_cfg(3'd1, 3'd1, 9'd40, 1'b0);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vl_strip_sequencer.md
# vl_strip_sequencer

Strip-mining controller for the vector unit. It accepts one vector configuration: SEW code, LMUL code and total application vector length (AVL). It then issues a sequence of chunks, each carrying the vector length `vl` for one strip, until the whole AVL is consumed. It sits between the vsetvl decode stage and the vector execution pipeline, and replaces per-instruction combinational vl computation with a registered, back-pressurable stream.

## Interface
Parameters:
- `VLEN`, default 64: vector register length in bits; must be a power of two, 16..64.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_valid`, in, 1: a configuration is offered.
- `cfg_ready`, out, 1: the sequencer can accept a configuration; high only in IDLE.
- `cfg_sew`, in, 3: SEW code. 000=4, 001=8, 010=16, 011=32, 100=64; 101..111 are illegal.
- `cfg_lmul`, in, 3: LMUL code. 000=1, 001=2, 010=4, 011=8, 100=16; 101..111 are illegal.
- `cfg_avl`, in, 9: total element count, 0..256.
- `chunk_valid`, out, 1: a chunk is presented.
- `chunk_ready`, in, 1: the downstream consumer accepts the chunk.
- `chunk_vl`, out, 9: element count of the current chunk, 1..256.
- `chunk_idx`, out, 8: zero-based chunk number within the job.
- `chunk_last`, out, 1: the current chunk is the final chunk of the job.
- `abort`, in, 1: flush the job in progress.
- `busy`, out, 1: a job is active (state ISSUE).
- `done`, out, 1: one-cycle pulse after the last chunk is accepted.
- `cfg_err`, out, 1: one-cycle pulse when a rejected configuration is consumed.

## Operation
- `vlmax = (VLEN >> (sew_code+2)) << lmul_code`, computed in 9 bits.
  - With VLEN=64 the range is 1 (SEW 64, LMUL 1) to 256 (SEW 4, LMUL 16).
- States: IDLE and ISSUE.
- IDLE:
  - `cfg_ready`=1; `chunk_valid`=0.
  - On `cfg_valid`, if either code is illegal or `cfg_avl`==0: pulse `cfg_err` next cycle and stay in IDLE. The configuration counts as consumed.
  - Otherwise latch `vlmax`. Set `remaining`=`cfg_avl`, `chunk_idx`=0, `chunk_vl`=min(`cfg_avl`, `vlmax`), and `chunk_last`=(`cfg_avl` <= `vlmax`). Go to ISSUE.
- ISSUE:
  - `chunk_valid`=1, `busy`=1.
  - `chunk_vl`, `chunk_idx` and `chunk_last` are registers and stay stable while `chunk_ready`=0.
  - On handshake with `chunk_last`=0: `remaining` -= `chunk_vl`; `chunk_idx`++. The next `chunk_vl` is min(new `remaining`, `vlmax`); `chunk_last` is recomputed the same way.
  - On handshake with `chunk_last`=1: go to IDLE and pulse `done`.
- Abort:
  - `abort` in ISSUE forces IDLE on the next edge. There is no `done` pulse.
  - `chunk_valid` may drop without a handshake; this is the only permitted retraction.
  - `abort` has priority over a simultaneous handshake.
  - `abort` in IDLE is ignored and does not block configuration acceptance.
- Arithmetic:
  - `remaining` never underflows, because `chunk_vl` <= `remaining` always holds.
  - `chunk_idx` reaches at most 255 (AVL 256, vlmax 1) and never wraps.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, `chunk_valid`=0, `chunk_vl`=0, `chunk_idx`=0, `chunk_last`=0, `busy`=0, `done`=0, `cfg_err`=0.
- Configuration accepted at edge N: first chunk valid in cycle N+1.
- With `chunk_ready` held high, one chunk is accepted per cycle; a job of k chunks occupies k cycles.
- Last handshake at edge M: `done`=1 and `cfg_ready`=1 in cycle M+1. The earliest next configuration is accepted at edge M+1, with no overlap between jobs.
- `cfg_err` follows the rejected configuration by one cycle; `cfg_ready` stays 1 throughout.
- Reset asserted mid-job: all outputs return to reset values immediately (asynchronous). Any partial job is lost.

## Structure
- Shared package `vl_pkg` holds:
  - SEW and LMUL code enums plus their illegal-code check;
  - the AVL and vl width (9) and the chunk_idx width (8);
  - the state enum.
- Sub-module `vlmax_calc`: combinational; inputs `VLEN`, SEW code and LMUL code; outputs `vlmax` and `legal`. It is reused by the decode stage.

## Test plan
- SEW 001, LMUL 001 (vlmax 16), AVL 40, ready held high: chunks vl=16, 16, 8 with idx 0, 1, 2; `chunk_last` only on idx 2; `done` one cycle after the third handshake.
- SEW 100, LMUL 000, AVL 3 and SEW 000, LMUL 100, AVL 256:
  - first case gives three chunks of vl=1;
  - second case gives a single chunk vl=256 with `chunk_last`=1.
- Back-pressure: vlmax 16, AVL 32, `chunk_ready` low for 3 cycles on idx 0. vl=16, idx=0 and last=0 hold stable; the next chunk is vl=16, idx=1, last=1.
- Rejects:
  - SEW 101 with AVL 10 gives a `cfg_err` pulse, no `chunk_valid`, and `cfg_ready` stays 1;
  - LMUL 110 gives the same response;
  - AVL 0 gives the same response.
- Abort asserted in the same cycle as the handshake of idx 1 (of 3): IDLE next cycle with no `done`. A new configuration is accepted immediately and its first chunk has idx=0.
- `rst` pulsed asynchronously mid-job: `chunk_valid` and `busy` drop without waiting for a clock edge. After release, all outputs hold reset values and a fresh job runs normally.
